// File: rtl/vyd_satir_yanitlayici.sv
// Memory-side responder for the L1 data cache request channel.
// Cacheable requests (address at or above BASLANGIC_ADRESI) become four ascending word
// beats on the memory bus. Lower addresses become one uncached word beat. Completion is
// signalled with a one-cycle hazir_o pulse, and the assembled line is presented on veri_o.
module vyd_satir_yanitlayici #(
    parameter int unsigned ADRES_GENISLIGI     = 32,
    parameter int unsigned SOZCUK_GENISLIGI    = 32,
    parameter int unsigned SATIR_SOZCUK_SAYISI = 4,
    parameter logic [ADRES_GENISLIGI-1:0] BASLANGIC_ADRESI = 32'h4000_0000
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          istek_i,
    input  logic                                          yaz_i,
    input  logic [ADRES_GENISLIGI-1:0]                    adres_i,
    input  logic [SATIR_SOZCUK_SAYISI*SOZCUK_GENISLIGI-1:0] veri_i,
    output logic                                          hazir_o,
    output logic [SATIR_SOZCUK_SAYISI*SOZCUK_GENISLIGI-1:0] veri_o,
    output logic                                          bellek_istek_o,
    output logic                                          bellek_yaz_o,
    output logic [ADRES_GENISLIGI-1:0]                    bellek_adres_o,
    output logic [SOZCUK_GENISLIGI-1:0]                   bellek_veri_o,
    input  logic                                          bellek_kabul_i,
    input  logic                                          bellek_gecerli_i,
    input  logic [SOZCUK_GENISLIGI-1:0]                   bellek_veri_i
);

    localparam int unsigned SatirGenisligi = SATIR_SOZCUK_SAYISI * SOZCUK_GENISLIGI;
    localparam int unsigned KGenisligi     = $clog2(SATIR_SOZCUK_SAYISI);
    localparam int unsigned BaytBitleri    = $clog2(SOZCUK_GENISLIGI / 8);
    localparam int unsigned SatirOfseti    = KGenisligi + BaytBitleri;
    localparam logic [KGenisligi-1:0] SonK = KGenisligi'(SATIR_SOZCUK_SAYISI - 1);

    typedef enum logic [1:0] {
        StBosta,
        StIstek,
        StYanitBekle,
        StTamam
    } durum_t;

    durum_t                       durum_q;
    logic [KGenisligi-1:0]        k_q;
    logic [KGenisligi-1:0]        k_sonraki;
    logic [ADRES_GENISLIGI-1:0]   adres_q;
    logic [SatirGenisligi-1:0]    veri_q;
    logic                         yaz_q;
    logic                         tek_q;
    logic                         yeni_tek;

    // Word address of beat k: line base with the word index spliced in.
    function automatic logic [ADRES_GENISLIGI-1:0] beat_adres(
        input logic [ADRES_GENISLIGI-1:0] a,
        input logic [KGenisligi-1:0]      k,
        input logic                       tek
    );
        if (tek) begin
            return a;
        end
        return {a[ADRES_GENISLIGI-1:SatirOfseti], k, {BaytBitleri{1'b0}}};
    endfunction

    // Write data for beat k; an uncached store always uses the lowest word.
    function automatic logic [SOZCUK_GENISLIGI-1:0] beat_veri(
        input logic [SatirGenisligi-1:0] v,
        input logic [KGenisligi-1:0]     k,
        input logic                      tek
    );
        if (tek) begin
            return v[SOZCUK_GENISLIGI-1:0];
        end
        return v[int'(k)*SOZCUK_GENISLIGI +: SOZCUK_GENISLIGI];
    endfunction

    // Classify the incoming request and compute the next beat index.
    always_comb begin
        yeni_tek  = (adres_i < BASLANGIC_ADRESI);
        k_sonraki = k_q + KGenisligi'(1);
    end

    // Request sequencer; all bus outputs are registered alongside the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q        <= StBosta;
            k_q            <= '0;
            adres_q        <= '0;
            veri_q         <= '0;
            yaz_q          <= 1'b0;
            tek_q          <= 1'b0;
            hazir_o        <= 1'b0;
            veri_o         <= '0;
            bellek_istek_o <= 1'b0;
            bellek_yaz_o   <= 1'b0;
            bellek_adres_o <= '0;
            bellek_veri_o  <= '0;
        end else begin
            case (durum_q)
                StBosta: begin
                    if (istek_i) begin
                        adres_q        <= adres_i;
                        veri_q         <= veri_i;
                        yaz_q          <= yaz_i;
                        tek_q          <= yeni_tek;
                        k_q            <= '0;
                        bellek_istek_o <= 1'b1;
                        bellek_yaz_o   <= yaz_i;
                        bellek_adres_o <= beat_adres(adres_i, '0, yeni_tek);
                        bellek_veri_o  <= beat_veri(veri_i, '0, yeni_tek);
                        durum_q        <= StIstek;
                    end
                end
                StIstek: begin
                    if (bellek_kabul_i) begin
                        bellek_istek_o <= 1'b0;
                        bellek_yaz_o   <= 1'b0;
                        bellek_adres_o <= '0;
                        bellek_veri_o  <= '0;
                        durum_q        <= StYanitBekle;
                    end
                end
                StYanitBekle: begin
                    if (bellek_gecerli_i) begin
                        if (!yaz_q) begin
                            if (tek_q) begin
                                veri_o <= SatirGenisligi'(bellek_veri_i);
                            end else begin
                                veri_o[int'(k_q)*SOZCUK_GENISLIGI +: SOZCUK_GENISLIGI] <=
                                    bellek_veri_i;
                            end
                        end
                        if (tek_q || (k_q == SonK)) begin
                            hazir_o <= 1'b1;
                            durum_q <= StTamam;
                        end else begin
                            k_q            <= k_sonraki;
                            bellek_istek_o <= 1'b1;
                            bellek_yaz_o   <= yaz_q;
                            bellek_adres_o <= beat_adres(adres_q, k_sonraki, tek_q);
                            bellek_veri_o  <= beat_veri(veri_q, k_sonraki, tek_q);
                            durum_q        <= StIstek;
                        end
                    end
                end
                StTamam: begin
                    // istek_i is deliberately not looked at here, so a held request
                    // is only taken again from StBosta.
                    hazir_o <= 1'b0;
                    durum_q <= StBosta;
                end
                default: begin
                    durum_q <= StBosta;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vyd_satir_yanitlayici.sv
// Self-checking bench for vyd_satir_yanitlayici: directed plan steps plus random
// transactions against a transaction-level expectation of beats, latency and line data.
module tb_vyd_satir_yanitlayici;

    localparam logic [31:0] Taban = 32'h4000_0000;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         istek_i;
    logic         yaz_i;
    logic [31:0]  adres_i;
    logic [127:0] veri_i;
    logic         hazir_o;
    logic [127:0] veri_o;
    logic         bellek_istek_o;
    logic         bellek_yaz_o;
    logic [31:0]  bellek_adres_o;
    logic [31:0]  bellek_veri_o;
    logic         bellek_kabul_i;
    logic         bellek_gecerli_i;
    logic [31:0]  bellek_veri_i;

    int           checks = 0;
    int           failures = 0;
    int           cyc;
    logic [127:0] model_satir = '0;

    vyd_satir_yanitlayici dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .istek_i          (istek_i),
        .yaz_i            (yaz_i),
        .adres_i          (adres_i),
        .veri_i           (veri_i),
        .hazir_o          (hazir_o),
        .veri_o           (veri_o),
        .bellek_istek_o   (bellek_istek_o),
        .bellek_yaz_o     (bellek_yaz_o),
        .bellek_adres_o   (bellek_adres_o),
        .bellek_veri_o    (bellek_veri_o),
        .bellek_kabul_i   (bellek_kabul_i),
        .bellek_gecerli_i (bellek_gecerli_i),
        .bellek_veri_i    (bellek_veri_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic kontrol(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sifir_kontrol(input string tag);
        kontrol({tag, "_hazir"}, 128'(hazir_o), 128'd0);
        kontrol({tag, "_veri_o"}, veri_o, 128'd0);
        kontrol({tag, "_b_istek"}, 128'(bellek_istek_o), 128'd0);
        kontrol({tag, "_b_yaz"}, 128'(bellek_yaz_o), 128'd0);
        kontrol({tag, "_b_adres"}, 128'(bellek_adres_o), 128'd0);
        kontrol({tag, "_b_veri"}, 128'(bellek_veri_o), 128'd0);
    endtask

    // Serves one memory beat starting at a negedge; returns at the negedge after gecerli.
    task automatic beat_hizmet(input int kg, input int gg, input logic [31:0] rd, input bit cevap,
                               input logic [31:0] e_a, input logic [31:0] e_w, input logic e_y);
        int          t;
        logic [31:0] a0;
        logic [31:0] w0;
        logic        y0;
        bit          stabil;
        t = 0;
        while (bellek_istek_o !== 1'b1 && t < 20) begin
            @(negedge clk);
            cyc++;
            t++;
        end
        kontrol("beat_istek", 128'(bellek_istek_o), 128'd1);
        a0 = bellek_adres_o;
        w0 = bellek_veri_o;
        y0 = bellek_yaz_o;
        kontrol("beat_adres", 128'(a0), 128'(e_a));
        kontrol("beat_yaz", 128'(y0), 128'(e_y));
        kontrol("beat_veri", 128'(w0), 128'(e_w));
        stabil = 1'b1;
        for (int i = 0; i < kg; i++) begin
            @(negedge clk);
            cyc++;
            if (bellek_istek_o !== 1'b1 || bellek_adres_o !== a0 || bellek_veri_o !== w0 ||
                bellek_yaz_o !== y0) begin
                stabil = 1'b0;
            end
        end
        if (kg > 0) kontrol("beat_stabil", 128'(stabil), 128'd1);
        bellek_kabul_i = 1'b1;
        @(negedge clk);
        cyc++;
        bellek_kabul_i = 1'b0;
        kontrol("istek_dusuk", 128'(bellek_istek_o), 128'd0);
        if (!cevap) return;
        for (int i = 0; i < gg; i++) begin
            @(negedge clk);
            cyc++;
        end
        bellek_gecerli_i = 1'b1;
        bellek_veri_i    = rd;
        @(negedge clk);
        cyc++;
        bellek_gecerli_i = 1'b0;
        bellek_veri_i    = $urandom();
    endtask

    // One full request. zincir: request already held high from the previous one.
    // birak: drop istek at hazir; otherwise present (ny, na, nv) as the next request.
    task automatic islem(input logic y, input logic [31:0] a, input logic [127:0] v,
                         input logic [127:0] okuma, input int kg, input int gg,
                         input bit zincir, input bit birak, input logic ny,
                         input logic [31:0] na, input logic [127:0] nv);
        int          n;
        int          t;
        int          bek_gecikme;
        logic [31:0] e_a;
        logic [31:0] e_w;
        if (!zincir) begin
            @(negedge clk);
            istek_i = 1'b1;
            yaz_i   = y;
            adres_i = a;
            veri_i  = v;
        end
        @(posedge clk);
        cyc = -1;
        @(negedge clk);
        cyc++;
        // Anything presented after acceptance must be ignored.
        adres_i = $urandom();
        veri_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
        yaz_i   = 1'($urandom());
        n = (a < Taban) ? 1 : 4;
        bek_gecikme = (n == 1) ? (3 + kg + gg) : (9 + 4 * (kg + gg));
        for (int i = 0; i < n; i++) begin
            e_a = (n == 1) ? a : ((a & 32'hFFFF_FFF0) + 32'(4 * i));
            e_w = (n == 1) ? v[31:0] : v[32*i +: 32];
            beat_hizmet(kg, gg, okuma[32*i +: 32], 1'b1, e_a, e_w, y);
        end
        t = 0;
        while (hazir_o !== 1'b1 && t < 10) begin
            @(negedge clk);
            cyc++;
            t++;
        end
        kontrol("hazir", 128'(hazir_o), 128'd1);
        kontrol("gecikme", 128'(cyc + 1), 128'(bek_gecikme));
        if (!y) model_satir = (n == 1) ? {96'd0, okuma[31:0]} : okuma;
        kontrol("veri_o", veri_o, model_satir);
        if (birak) begin
            istek_i = 1'b0;
        end else begin
            yaz_i   = ny;
            adres_i = na;
            veri_i  = nv;
        end
        @(negedge clk);
        kontrol("hazir_darbe", 128'(hazir_o), 128'd0);
        kontrol("bosta_istek", 128'(bellek_istek_o), 128'd0);
    endtask

    initial begin
        logic [127:0] v;
        logic [127:0] okuma;
        logic [31:0]  a;
        logic         y;
        rst_i            = 1'b1;
        istek_i          = 1'b0;
        yaz_i            = 1'b0;
        adres_i          = '0;
        veri_i           = '0;
        bellek_kabul_i   = 1'b0;
        bellek_gecerli_i = 1'b0;
        bellek_veri_i    = '0;

        repeat (3) @(negedge clk);
        sifir_kontrol("reset_icinde");
        rst_i = 1'b0;
        @(negedge clk);
        sifir_kontrol("reset_sonrasi");

        // Zero-wait line fill.
        islem(1'b0, 32'h4000_0010, 128'h0,
              {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011},
              0, 0, 1'b0, 1'b1, 1'b0, 32'h0, 128'h0);
        kontrol("dolum_satir", veri_o, 128'h00000044_00000033_00000022_00000011);

        // Write-back with istek held high into a fill of the same line.
        v = {$urandom(), $urandom(), $urandom(), $urandom()};
        islem(1'b1, 32'h4000_0100, 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA, 128'h0,
              0, 0, 1'b0, 1'b0, 1'b0, 32'h4000_0100, v);
        okuma = {$urandom(), $urandom(), $urandom(), $urandom()};
        islem(1'b0, 32'h4000_0100, v, okuma, 0, 0, 1'b1, 1'b1, 1'b0, 32'h0, 128'h0);

        // Uncached read and write.
        islem(1'b0, 32'h2000_0004, 128'h0, {96'h0, 32'hCAFE_F00D},
              0, 0, 1'b0, 1'b1, 1'b0, 32'h0, 128'h0);
        kontrol("tek_okuma", veri_o, {96'h0, 32'hCAFE_F00D});
        islem(1'b1, 32'h2000_0008, {96'hFFFF_0000_FFFF_0000_FFFF_0000, 32'h1234_5678}, 128'h0,
              0, 0, 1'b0, 1'b1, 1'b0, 32'h0, 128'h0);

        // Wait states on every beat.
        okuma = {$urandom(), $urandom(), $urandom(), $urandom()};
        islem(1'b0, 32'h7000_0040, 128'h0, okuma, 2, 3, 1'b0, 1'b1, 1'b0, 32'h0, 128'h0);

        // Reset in the middle of beat 2.
        @(negedge clk);
        istek_i = 1'b1;
        yaz_i   = 1'b0;
        adres_i = 32'h4000_0200;
        veri_i  = '0;
        @(posedge clk);
        cyc = -1;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            beat_hizmet(0, 0, $urandom(), (i < 2), 32'h4000_0200 + 32'(4 * i), 32'h0, 1'b0);
        end
        rst_i   = 1'b1;
        istek_i = 1'b0;
        #1;
        sifir_kontrol("reset_ortada");
        @(negedge clk);
        rst_i            = 1'b0;
        bellek_gecerli_i = 1'b1;
        bellek_veri_i    = 32'hDEAD_BEEF;
        @(negedge clk);
        bellek_gecerli_i = 1'b0;
        sifir_kontrol("basibos_gecerli");
        model_satir = '0;

        // Boundary addresses.
        okuma = {$urandom(), $urandom(), $urandom(), $urandom()};
        islem(1'b0, Taban, 128'h0, okuma, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0, 128'h0);
        okuma = {$urandom(), $urandom(), $urandom(), $urandom()};
        islem(1'b0, Taban - 32'd4, 128'h0, okuma, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0, 128'h0);

        // Random transactions.
        for (int r = 0; r < 12; r++) begin
            y = 1'($urandom());
            a = $urandom();
            if ($urandom_range(0, 1) == 0) begin
                a = a & 32'h3FFF_FFFC;
            end else begin
                a = a & 32'hFFFF_FFF0;
                if (a < Taban) a = a + Taban;
            end
            v     = {$urandom(), $urandom(), $urandom(), $urandom()};
            okuma = {$urandom(), $urandom(), $urandom(), $urandom()};
            islem(y, a, v, okuma, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  1'b0, 1'b1, 1'b0, 32'h0, 128'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
